pacoblaze_scratch_loader: RTL and testbench
===========================================

// Module: pacoblaze_scratch_loader
// PURPOSE
//  Bus-master on the scratch-pad RAM port: bulk-loads bytes from an input stream into the scratch-pad
//  (LOAD) or dumps a scratch-pad range to an output stream (DUMP), under a request/grant handoff with the CPU.
//  Sits beside the PacoBlaze core; an external mux selects the core or this block onto the RAM port using req/gnt.
// PARAMETERS
//  DEPTH  6  scratch-pad address width (2**DEPTH locations)
//  WIDTH  8  scratch-pad data width
// PORTS
//  clk             in   1      rising-edge clock, sole clock
//  reset           in   1      asynchronous, active-low reset
//  cmd_valid       in   1      command offered
//  cmd_ready       out  1      command accepted when cmd_valid & cmd_ready
//  cmd_load        in   1      1 = LOAD (stream -> RAM), 0 = DUMP (RAM -> stream)
//  cmd_base        in   DEPTH  first address
//  cmd_len         in   DEPTH  transfer count minus 1 (1..2**DEPTH bytes)
//  req             out  1      request for RAM port ownership
//  gnt             in   1      RAM port owned by this block while high
//  spr_address     out  DEPTH  RAM address
//  spr_write_enable out 1      RAM write strobe
//  spr_data_in     out  WIDTH  RAM write data
//  spr_data_out    in   WIDTH  RAM read data, combinational from spr_address
//  s_valid/s_ready in/out 1    LOAD input stream handshake
//  s_data          in   WIDTH  LOAD input byte
//  m_valid/m_ready out/in 1    DUMP output stream handshake
//  m_data          out  WIDTH  DUMP output byte (registered)
//  busy            out  1      high from command accept until done
//  done            out  1      one-cycle pulse when the last byte completes
//  checksum        out  WIDTH  running sum of transferred bytes (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1, req=0, spr_write_enable=0, s_ready=0, m_valid=0, busy=0, done=0,
//    spr_address=0, spr_data_in=0, m_data=0, checksum=0. Reset mid-transfer aborts it; no done pulse.
//  - States: IDLE -> REQ on cmd accept (latch load/base/len, cnt=len, busy=1, req=1, checksum cleared);
//    REQ -> XFER when gnt=1; XFER -> DRAIN after last byte (DUMP) or DONE directly (LOAD);
//    DRAIN -> DONE when m_valid&m_ready; DONE: done=1, req=0, busy=0, -> IDLE next cycle.
//  - cmd_ready=1 only in IDLE; commands offered while busy are not accepted.
//  - LOAD/XFER: s_ready = gnt. Each s_valid&s_ready cycle: spr_write_enable=1, spr_data_in=s_data,
//    write in that same cycle (combinational strobe, registered address); address += 1, cnt -= 1.
//  - DUMP/XFER: when gnt and (m_valid=0 or m_ready=1): m_data <= spr_data_out, m_valid <= 1, address += 1,
//    cnt -= 1. Latency address-to-m_data 1 cycle; full throughput 1 byte/cycle with m_ready held high.
//    spr_write_enable is never asserted in DUMP.
//  - Address arithmetic modulo 2**DEPTH: base=62,len=3 touches 62,63,0,1.
//  - cnt==0 transfer is the last; len=2**DEPTH-1 covers whole RAM once.
//  - gnt deasserted in XFER: pause; s_ready=0, no RAM strobe, no address advance; m_valid/m_data held
//    until consumed. Resume on gnt=1 with no lost or duplicated byte. req stays high until DONE.
//  - spr_address/spr_data_in are don't-care while gnt=0; spr_write_enable is 0 whenever gnt=0.
// CONFIGURATION
//  SCRATCH_LOADER_CHECKSUM_EN defined: checksum accumulates (mod 2**WIDTH) every byte written (LOAD) or
//    emitted on m_valid&m_ready (DUMP); cleared on command accept; holds after done until next command.
//  Not defined: checksum tied to 0, accumulator logic absent; all other behaviour identical.
// TESTING
//  1 Reset: hold reset=0 mid-LOAD with gnt=1 -> all outputs at reset values, no further RAM writes.
//  2 LOAD base=5 len=3, gnt=1, stream 11,22,33,44 -> RAM[5..8]=11,22,33,44; one done pulse; checksum=6E (EN).
//  3 DUMP base=62 len=3 with RAM[62,63,0,1]=A0,A1,A2,A3, m_ready=1 -> m_data A0,A1,A2,A3 on 4 cycles, done.
//  4 DUMP with m_ready toggling 1,0,0,1 -> m_data stable while stalled; order preserved; no duplicates.
//  5 LOAD len=7 with gnt dropped for 3 cycles after byte 2 -> no strobe while gnt=0; RAM gets all 8 bytes.
//  6 cmd_valid during busy -> cmd_ready=0, command ignored; accepted the cycle after DONE.

Source files
------------

// File: rtl/pacoblaze_scratch_loader_if.sv
// Bundle of the command, RAM-port, stream and status signals of the
// scratch-pad loader. "master" is the loader side and "slave" is the
// environment side (CPU/mux/RAM/stream endpoints).
interface pacoblaze_scratch_loader_if #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 8
);
  // command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [DEPTH-1:0] cmd_base;
  logic [DEPTH-1:0] cmd_len;
  // RAM port ownership handoff
  logic             req;
  logic             gnt;
  // scratch-pad RAM port
  logic [DEPTH-1:0] spr_address;
  logic             spr_write_enable;
  logic [WIDTH-1:0] spr_data_in;
  logic [WIDTH-1:0] spr_data_out;
  // LOAD input stream
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  // DUMP output stream
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  // status
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] checksum;

  modport master (
    input  cmd_valid, cmd_load, cmd_base, cmd_len, gnt, spr_data_out,
           s_valid, s_data, m_ready,
    output cmd_ready, req, spr_address, spr_write_enable, spr_data_in,
           s_ready, m_valid, m_data, busy, done, checksum
  );

  modport slave (
    output cmd_valid, cmd_load, cmd_base, cmd_len, gnt, spr_data_out,
           s_valid, s_data, m_ready,
    input  cmd_ready, req, spr_address, spr_write_enable, spr_data_in,
           s_ready, m_valid, m_data, busy, done, checksum
  );
endinterface

// File: rtl/pacoblaze_scratch_loader.sv
// Scratch-pad bus master for the PacoBlaze core. LOAD copies bytes from an
// input stream into the scratch-pad, DUMP streams a scratch-pad range out.
// The RAM port is borrowed from the CPU with a req/gnt handoff; while gnt is
// low the transfer pauses without losing or repeating a byte.
// Optional feature: define SCRATCH_LOADER_CHECKSUM_EN to enable the running
// byte checksum; otherwise checksum is tied to zero.
module pacoblaze_scratch_loader #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  pacoblaze_scratch_loader_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic             load_q;
  logic [DEPTH-1:0] addr_q;
  logic [DEPTH-1:0] cnt_q;
  logic             cmd_ready_q;
  logic             req_q;
  logic             busy_q;
  logic             done_q;
  logic             vld_p1;
  logic [WIDTH-1:0] m_data_p1;

  logic xfer_gnt;
  logic wr_fire;
  logic rd_fire;
  logic m_take;
  logic last;

  // Transfer qualifiers: nothing moves on the RAM port unless it is granted.
  assign xfer_gnt = (state == XFER) && bus.gnt;
  assign wr_fire  = xfer_gnt && load_q && bus.s_valid;
  assign rd_fire  = xfer_gnt && !load_q && (!vld_p1 || bus.m_ready);
  assign m_take   = vld_p1 && bus.m_ready;
  assign last     = (cnt_q == '0);

  // The write strobe is combinational so a byte lands in the same cycle it
  // is accepted; address is the registered transfer pointer.
  assign bus.s_ready          = xfer_gnt && load_q;
  assign bus.spr_write_enable = wr_fire;
  assign bus.spr_data_in      = wr_fire ? bus.s_data : '0;
  assign bus.spr_address      = addr_q;
  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.req              = req_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.m_valid          = vld_p1;
  assign bus.m_data           = m_data_p1;

  // Control FSM with registered outputs; also owns the address/count pointers
  // and the one-deep DUMP output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      load_q      <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vld_p1      <= 1'b0;
      m_data_p1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            load_q      <= bus.cmd_load;
            addr_q      <= bus.cmd_base;
            cnt_q       <= bus.cmd_len;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b1;
            busy_q      <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus.gnt) state <= XFER;
        end
        XFER: begin
          if (wr_fire) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
            if (last) begin
              req_q  <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
          if (rd_fire) begin
            m_data_p1 <= bus.spr_data_out;
            vld_p1    <= 1'b1;
            addr_q    <= addr_q + 1'b1;
            cnt_q     <= cnt_q - 1'b1;
            if (last) state <= DRAIN;
          end else if (m_take) begin
            vld_p1 <= 1'b0;
          end
        end
        DRAIN: begin
          if (m_take) begin
            vld_p1 <= 1'b0;
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
          req_q       <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          vld_p1      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCRATCH_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q;

  // Running modulo sum of every byte written (LOAD) or handed off (DUMP).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (state == IDLE && bus.cmd_valid) begin
      sum_q <= '0;
    end else if (wr_fire) begin
      sum_q <= sum_q + bus.s_data;
    end else if (m_take) begin
      sum_q <= sum_q + m_data_p1;
    end
  end

  assign bus.checksum = sum_q;
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_pacoblaze_scratch_loader.sv
// Bench for pacoblaze_scratch_loader: a RAM model on the scratch-pad port, a
// reference image of the RAM updated per command, and directed plus random
// LOAD/DUMP commands with gnt drops and m_ready back-pressure.
module tb_pacoblaze_scratch_loader;
  localparam int DEPTH = 6;
  localparam int WIDTH = 8;
  localparam int N     = 1 << DEPTH;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pacoblaze_scratch_loader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  pacoblaze_scratch_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // scratch-pad RAM model: combinational read, write on rising edge
  logic [7:0] mem [N];
  int         wr_cnt = 0;
  assign bus.spr_data_out = mem[bus.spr_address];
  always @(posedge clk) begin
    if (bus.spr_write_enable) begin
      mem[bus.spr_address] <= bus.spr_data_in;
      wr_cnt <= wr_cnt + 1;
    end
  end

  logic [7:0] ref_mem [N];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_req"}, bus.req, 0);
    check({tag, "_we"}, bus.spr_write_enable, 0);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_addr"}, bus.spr_address, 0);
    check({tag, "_din"}, bus.spr_data_in, 0);
    check({tag, "_m_data"}, bus.m_data, 0);
    check({tag, "_checksum"}, bus.checksum, 0);
  endtask

  task automatic issue(input bit ld, input int base, input int len);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_base  = DEPTH'(base);
    bus.cmd_len   = DEPTH'(len);
    bus.gnt       = 1'b1;
    #1;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    check("busy_after_accept", bus.busy, 1);
    check("req_after_accept", bus.req, 1);
  endtask

  // Runs one accepted command to completion and checks it against the
  // reference RAM image. drop_at/drop_len: gnt low for drop_len cycles once
  // drop_at bytes have moved. mr_mode: 0 ready high, 1 pattern 1,0,0,1, 2 random.
  task automatic complete(input bit ld, input int base, input int len,
                          input int drop_at, input int drop_len, input int mr_mode,
                          input bit sv_rand, input bit hold,
                          input bit drand, input int dstart, input int dstep);
    logic [7:0] dat [N];
    logic [7:0] got [$];
    int taken = 0, left = drop_len, first = -1, lastc = -1, dones = 0;
    int viol_we = 0, viol_stab = 0, viol_cmd = 0, w0 = wr_cnt, sum = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;
    logic [31:0] exp_ck;
    for (int i = 0; i < N; i++)
      dat[i] = drand ? 8'($urandom) : 8'(dstart + i * dstep);
    for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
      @(negedge clk);
      if (taken == drop_at && left > 0) begin
        bus.gnt = 1'b0;
        left--;
      end else begin
        bus.gnt = 1'b1;
      end
      bus.s_valid = ld && (taken <= len) && (!sv_rand || ($urandom % 4 != 0));
      bus.s_data  = (taken <= len) ? dat[taken] : 8'h00;
      case (mr_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: bus.m_ready = ($urandom % 3 != 0);
      endcase
      #1;
      if (!bus.gnt && (bus.spr_write_enable || bus.s_ready)) viol_we++;
      if (!ld && bus.spr_write_enable) viol_we++;
      if (hold && bus.cmd_ready) viol_cmd++;
      if (pv && !pr && !(bus.m_valid && bus.m_data == pd)) viol_stab++;
      pv = bus.m_valid;
      pr = bus.m_ready;
      pd = bus.m_data;
      if (ld && bus.s_valid && bus.s_ready) begin
        sum += dat[taken];
        taken++;
      end
      if (!ld && bus.m_valid && bus.m_ready) begin
        got.push_back(bus.m_data);
        sum += bus.m_data;
        if (first < 0) first = cyc;
        lastc = cyc;
        taken++;
      end
      if (bus.done) begin
        dones++;
`ifdef SCRATCH_LOADER_CHECKSUM_EN
        exp_ck = sum % 256;
`else
        exp_ck = 0;
`endif
        check("done_busy_low", bus.busy, 0);
        check("done_req_low", bus.req, 0);
        check("checksum", bus.checksum, exp_ck);
      end
    end
    check("done_pulses", dones, 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
    check("done_one_cycle", bus.done, 0);
    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("no_strobe_violation", viol_we, 0);
    check("m_data_stable_stall", viol_stab, 0);
    check("cmd_ignored_busy", viol_cmd, 0);
    if (ld) begin
      for (int i = 0; i <= len; i++) ref_mem[(base + i) % N] = dat[i];
      check("load_write_count", wr_cnt - w0, len + 1);
      for (int i = 0; i < N; i++) check("ram_image", mem[i], ref_mem[i]);
    end else begin
      check("dump_write_count", wr_cnt - w0, 0);
      check("dump_byte_count", got.size(), len + 1);
      for (int i = 0; i <= len && i < got.size(); i++)
        check("dump_byte", got[i], ref_mem[(base + i) % N]);
      if (mr_mode == 0 && drop_len == 0) check("dump_throughput", lastc - first, len);
    end
  endtask

  initial begin
    int taken;
    int w0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.gnt       = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.m_ready   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    // whole RAM, wrapping from base 17, random data and stalls
    issue(1, 17, N - 1);
    complete(1, 17, N - 1, -1, 0, 0, 1, 0, 1, 0, 0);

    // LOAD 11,22,33,44 at 5..8 (sum 0x6E)
    issue(1, 5, 3);
    complete(1, 5, 3, -1, 0, 0, 0, 0, 0, 11, 11);

    // wrap-around LOAD then DUMP at 62,63,0,1
    issue(1, 62, 3);
    complete(1, 62, 3, -1, 0, 0, 0, 0, 0, 8'hA0, 1);
    issue(0, 62, 3);
    complete(0, 62, 3, -1, 0, 0, 0, 0, 0, 0, 0);

    // DUMP with m_ready 1,0,0,1 back-pressure
    issue(0, 10, 5);
    complete(0, 10, 5, -1, 0, 1, 0, 0, 0, 0, 0);

    // LOAD len=7 with gnt dropped 3 cycles after byte 2
    issue(1, 30, 7);
    complete(1, 30, 7, 2, 3, 0, 0, 0, 1, 0, 0);

    // DUMP with gnt dropped while output is held
    issue(0, 30, 7);
    complete(0, 30, 7, 3, 2, 1, 0, 0, 0, 0, 0);

    // command offered while busy is ignored, then accepted after DONE
    issue(1, 40, 3);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_base  = DEPTH'(40);
    bus.cmd_len   = DEPTH'(3);
    complete(1, 40, 3, -1, 0, 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    check("held_cmd_accepted", bus.busy, 1);
    complete(0, 40, 3, -1, 0, 0, 0, 0, 0, 0, 0);

    // random commands
    for (int k = 0; k < 8; k++) begin
      bit ld;
      int base, len, da, dl;
      ld   = 1'($urandom % 2);
      base = $urandom % N;
      len  = $urandom % 20;
      da   = $urandom % (len + 1);
      dl   = $urandom % 4;
      issue(ld, base, len);
      complete(ld, base, len, da, dl, 2, 1, 0, 1, 0, 0);
    end

    // reset in the middle of a granted LOAD
    issue(1, 50, 9);
    taken = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.gnt     = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(8'h5A + c);
      #1;
      if (bus.s_valid && bus.s_ready) begin
        ref_mem[(50 + taken) % N] = bus.s_data;
        taken++;
      end
    end
    @(negedge clk);
    bus.s_data = 8'h77;
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    w0 = wr_cnt;
    repeat (3) @(negedge clk);
    #1;
    check("reset_no_writes", wr_cnt - w0, 0);
    check("reset_bytes_before", taken, 2);
    check_reset_vals("held_reset");
    bus.s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // recovery after reset: read back the bytes written before the abort
    issue(0, 50, 1);
    complete(0, 50, 1, -1, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
